// File: rtl/wb_queue_pkg.sv
// Shared types and helpers for the writeback queue: write size encoding,
// the stored queue entry, and slot-position normalisation.
package wb_queue_pkg;

  localparam int unsigned WB_XLEN = 64;
  localparam int unsigned WB_XWDT = 6;

  typedef enum logic [1:0] {
    WS_BYTE = 2'b00,
    WS_HALF = 2'b01,
    WS_WORD = 2'b10,
    WS_FULL = 2'b11
  } wsize_t;

  typedef struct packed {
    logic [WB_XWDT-1:0] dst;
    logic [WB_XLEN-1:0] data;
    wsize_t             size;
    logic [2:0]         pos;
  } wb_entry_t;

  // Keep only the slot bits that are meaningful for the given write size.
  function automatic logic [2:0] norm_pos(wsize_t size, logic [2:0] pos);
    logic [2:0] res;
    case (size)
      WS_BYTE: res = pos;
      WS_HALF: res = {1'b0, pos[1:0]};
      WS_WORD: res = {2'b00, pos[0]};
      default: res = 3'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_queue_batch_select.sv
// Combinational batch selection over the head window of the queue.
// A lane is taken only if every earlier lane was taken and its destination
// differs from all earlier lanes, so order is never violated.
module wb_batch_select
  import wb_queue_pkg::*;
#(
  parameter int unsigned XWDT = 6,
  parameter int unsigned PA   = 3,
  parameter int unsigned CW   = 4
) (
  input  logic [CW-1:0]          count_i,
  input  logic                   hold_i,
  input  logic [PA-1:0][XWDT-1:0] win_reg_i,
  output logic [PA-1:0]          sel_o,
  output logic [CW-1:0]          bsize_o
);

  logic go;
  logic ok;

  // Walk lanes in order; the first failing lane ends the batch.
  always_comb begin
    sel_o   = '0;
    bsize_o = '0;
    ok      = 1'b0;
    go      = (count_i != '0) && !hold_i;
    for (int k = 0; k < int'(PA); k++) begin
      ok = go && (CW'(k) < count_i);
      for (int j = 0; j < k; j++) begin
        if (win_reg_i[j] == win_reg_i[k]) ok = 1'b0;
      end
      sel_o[k] = ok;
      go       = ok;
      if (ok) bsize_o = bsize_o + 1'b1;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue feeding the register file parallel write lanes.
// Buffers up to DEPTH results and drains a conflict-free batch per cycle.
// Optional pending-write scoreboard output enabled by WB_SCOREBOARD_EN.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned XWDT           = 6,
  parameter int unsigned XN             = 64,
  parameter int unsigned PARALLELACCESS = 3,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [XWDT-1:0]                in_reg,
  input  logic [XLEN-1:0]                in_data,
  input  logic [1:0]                     in_size,
  input  logic [2:0]                     in_pos,
  input  logic                           hold,
  output logic [PARALLELACCESS*XWDT-1:0] rwrites,
  output logic [PARALLELACCESS*XLEN-1:0] rins,
  output logic [PARALLELACCESS*2-1:0]    rwsizes,
  output logic [PARALLELACCESS*3-1:0]    rwposs,
  output logic                           we,
  output logic [$clog2(DEPTH):0]         count
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [XN-1:0]                  pend
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PA = PARALLELACCESS;

  wb_entry_t          mem_q [DEPTH];
  logic [AW-1:0]      head_q, tail_q;
  logic [CW-1:0]      count_q, count_d;
  logic               we_q;
  logic [PA-1:0][XWDT-1:0] lane_reg_q, lane_reg_d;
  logic [PA-1:0][XLEN-1:0] lane_data_q, lane_data_d;
  logic [PA-1:0][1:0]      lane_size_q, lane_size_d;
  logic [PA-1:0][2:0]      lane_pos_q, lane_pos_d;

  wb_entry_t               win [PA];
  logic [PA-1:0][XWDT-1:0] win_reg;
  logic [PA-1:0]           sel;
  logic [CW-1:0]           bsize;
  logic                    enq;
  wb_entry_t               new_entry;

  assign in_ready = (count_q < CW'(DEPTH));
  assign enq      = in_valid && in_ready;
  assign count    = count_q;
  assign we       = we_q;
  assign rwrites  = lane_reg_q;
  assign rins     = lane_data_q;
  assign rwsizes  = lane_size_q;
  assign rwposs   = lane_pos_q;

  // Normalise the slot position on the way in; data is stored untouched.
  always_comb begin
    new_entry.dst  = in_reg;
    new_entry.data = in_data;
    new_entry.size = wsize_t'(in_size);
    new_entry.pos  = norm_pos(wsize_t'(in_size), in_pos);
  end

  // Head window (wraps modulo DEPTH) and next lane contents; unused lanes copy lane 0.
  always_comb begin
    for (int k = 0; k < int'(PA); k++) begin
      win[k]     = mem_q[head_q + AW'(k)];
      win_reg[k] = win[k].dst;
    end
    for (int k = 0; k < int'(PA); k++) begin
      lane_reg_d[k]  = sel[k] ? win[k].dst  : win[0].dst;
      lane_data_d[k] = sel[k] ? win[k].data : win[0].data;
      lane_size_d[k] = sel[k] ? win[k].size : win[0].size;
      lane_pos_d[k]  = sel[k] ? win[k].pos  : win[0].pos;
    end
  end

  wb_batch_select #(
    .XWDT (XWDT),
    .PA   (PA),
    .CW   (CW)
  ) u_batch_select (
    .count_i   (count_q),
    .hold_i    (hold),
    .win_reg_i (win_reg),
    .sel_o     (sel),
    .bsize_o   (bsize)
  );

  assign count_d = count_q + CW'(enq) - bsize;

  // Queue storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= new_entry;
  end

  // Queue pointers, occupancy and the registered output lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      we_q        <= 1'b0;
      lane_reg_q  <= '0;
      lane_data_q <= '0;
      lane_size_q <= '0;
      lane_pos_q  <= '0;
    end else begin
      head_q  <= head_q + AW'(bsize);
      count_q <= count_d;
      we_q    <= (bsize != '0);
      if (enq) tail_q <= tail_q + 1'b1;
      if (bsize != '0) begin
        lane_reg_q  <= lane_reg_d;
        lane_data_q <= lane_data_d;
        lane_size_q <= lane_size_d;
        lane_pos_q  <= lane_pos_d;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [XN-1:0] pend_q, pend_d;
  logic [AW-1:0] off;

  // Everything queued now is either still queued or on a live lane after the
  // edge, so the next scoreboard is the current queue plus the new entry.
  always_comb begin
    pend_d = '0;
    off    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off = AW'(i) - head_q;
      if (CW'(off) < count_q) pend_d[mem_q[i].dst] = 1'b1;
    end
    if (enq) pend_d[in_reg] = 1'b1;
  end

  // Scoreboard register, updated on the same edge as the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend = pend_q;
`endif

endmodule
